// File: rtl/cruce_peatonal_pkg.sv
// Shared definitions for the pedestrian crossing block: light codes, FSM
// state encodings and the constant helpers used to size counters.
package cruce_peatonal_pkg;

  localparam logic [1:0] ROJO     = 2'b00;
  localparam logic [1:0] AMARILLO = 2'b01;
  localparam logic [1:0] VERDE    = 2'b10;
  localparam logic [1:0] ILEGAL   = 2'b11;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SOLICITUD = 2'd1;
  localparam logic [1:0] PASO      = 2'd2;
  localparam logic [1:0] PARPADEO  = 2'd3;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >>> 1;
    end
    return res;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cruce_peatonal_lado.sv
// One street side: button synchroniser and debouncer, request/walk FSM,
// phase timer and blink generator. Lamp and request outputs are registered.
module cruce_lado
  import cruce_peatonal_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int WALK_CYC     = 10,
  parameter int CLEAR_CYC    = 6,
  parameter int BLINK_CYC    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       boton,
  input  logic [1:0] semaforo,
  output logic       peatonal,
  output logic       paso
);

  localparam int DW = clog2(DEBOUNCE_CYC) + 1;
  localparam int TW = clog2(max3(WALK_CYC, CLEAR_CYC, BLINK_CYC)) + 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYC);
  localparam logic [TW-1:0] WALK_T  = TW'(WALK_CYC);
  localparam logic [TW-1:0] CLEAR_T = TW'(CLEAR_CYC);
  localparam logic [TW-1:0] BLINK_T = TW'(BLINK_CYC);
  localparam logic [TW-1:0] ONE_T   = TW'(1);

  logic [1:0]    sync_r;
  logic [DW-1:0] deb_r, deb_n;
  logic          press_r, press_n;
  logic [1:0]    light_r;
  logic [1:0]    state_r, state_n;
  logic [TW-1:0] timer_r, timer_n;
  logic [TW-1:0] blink_r, blink_n;
  logic          phase_r, phase_n;

  // Press pulse fires only on the cycle the saturating counter reaches the limit.
  always_comb begin
    deb_n   = deb_r;
    press_n = 1'b0;
    if (sync_r[1]) begin
      if (deb_r != DEB_MAX) begin
        deb_n = deb_r + DW'(1);
      end else begin
        deb_n = deb_r;
      end
      press_n = (deb_r == (DEB_MAX - DW'(1)));
    end else begin
      deb_n = '0;
    end
  end

  // The FSM acts on the registered light code; a not-red light always wins over the timers.
  always_comb begin
    state_n = state_r;
    timer_n = timer_r;
    blink_n = blink_r;
    phase_n = phase_r;
    case (state_r)
      IDLE: begin
        if (press_r) state_n = SOLICITUD;
        else         state_n = IDLE;
      end
      SOLICITUD: begin
        if (light_r == ROJO) begin
          state_n = PASO;
          timer_n = WALK_T;
        end else begin
          state_n = SOLICITUD;
        end
      end
      PASO: begin
        if (light_r != ROJO) begin
          state_n = IDLE;
        end else if (timer_r == ONE_T) begin
          state_n = PARPADEO;
          timer_n = CLEAR_T;
          blink_n = BLINK_T;
          phase_n = 1'b0;
        end else begin
          timer_n = timer_r - ONE_T;
        end
      end
      PARPADEO: begin
        if (light_r != ROJO || timer_r == ONE_T) begin
          state_n = IDLE;
        end else begin
          timer_n = timer_r - ONE_T;
          if (blink_r == ONE_T) begin
            blink_n = BLINK_T;
            phase_n = ~phase_r;
          end else begin
            blink_n = blink_r - ONE_T;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and output registers; everything holds while enb is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r   <= 2'b00;
      deb_r    <= '0;
      press_r  <= 1'b0;
      light_r  <= ROJO;
      state_r  <= IDLE;
      timer_r  <= '0;
      blink_r  <= '0;
      phase_r  <= 1'b0;
      peatonal <= 1'b0;
      paso     <= 1'b0;
    end else if (enb) begin
      sync_r   <= {sync_r[0], boton};
      deb_r    <= deb_n;
      press_r  <= press_n;
      light_r  <= semaforo;
      state_r  <= state_n;
      timer_r  <= timer_n;
      blink_r  <= blink_n;
      phase_r  <= phase_n;
      peatonal <= (state_n == SOLICITUD);
      paso     <= (state_n == PASO) || ((state_n == PARPADEO) && phase_n);
    end
  end

endmodule

// File: rtl/cruce_peatonal.sv
// Pedestrian-side interface for the calle controller: two independent street
// sides plus an optional sticky fault monitor enabled by CRUCE_FALLA_EN.
module cruce_peatonal
  import cruce_peatonal_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int WALK_CYC     = 10,
  parameter int CLEAR_CYC    = 6,
  parameter int BLINK_CYC    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       boton_a,
  input  logic       boton_b,
  input  logic [1:0] semaforo_a,
  input  logic [1:0] semaforo_b,
  output logic       a_peatonal,
  output logic       b_peatonal,
  output logic       paso_a,
  output logic       paso_b,
  output logic       falla
);

  logic paso_a_s;
  logic paso_b_s;

  cruce_lado #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .WALK_CYC(WALK_CYC),
    .CLEAR_CYC(CLEAR_CYC), .BLINK_CYC(BLINK_CYC)
  ) u_lado_a (
    .clk(clk), .reset(reset), .enb(enb), .boton(boton_a),
    .semaforo(semaforo_a), .peatonal(a_peatonal), .paso(paso_a_s)
  );

  cruce_lado #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .WALK_CYC(WALK_CYC),
    .CLEAR_CYC(CLEAR_CYC), .BLINK_CYC(BLINK_CYC)
  ) u_lado_b (
    .clk(clk), .reset(reset), .enb(enb), .boton(boton_b),
    .semaforo(semaforo_b), .peatonal(b_peatonal), .paso(paso_b_s)
  );

`ifdef CRUCE_FALLA_EN
  logic falla_r;
  logic fault_s;

  // Fault is judged on the live light codes so it latches on the same edge.
  always_comb begin
    fault_s = (semaforo_a == ILEGAL) || (semaforo_b == ILEGAL) ||
              ((semaforo_a == VERDE) && (semaforo_b == VERDE)) ||
              (paso_a_s && (semaforo_a != ROJO)) ||
              (paso_b_s && (semaforo_b != ROJO));
  end

  // Sticky fault flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      falla_r <= 1'b0;
    end else if (enb) begin
      falla_r <= falla_r | fault_s;
    end
  end

  assign falla  = falla_r;
  assign paso_a = paso_a_s & ~falla_r;
  assign paso_b = paso_b_s & ~falla_r;
`else
  assign falla  = 1'b0;
  assign paso_a = paso_a_s;
  assign paso_b = paso_b_s;
`endif

endmodule
